// File: rtl/core_hazard_ctrl.sv
// Decode-stage pipeline sequencer for KayRV32: load-use bubbles, branch flushes,
// and the event drain-and-halt sequence, plus a saturating stall-cycle counter.
module core_hazard_ctrl #(
    parameter int LOAD_LAT  = 1,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 32
) (
    input  logic             i_Clk,
    input  logic             i_Rstn,
    input  logic [4:0]       i_Rs1,
    input  logic [4:0]       i_Rs2,
    input  logic             i_UseRs1,
    input  logic             i_UseRs2,
    input  logic             i_ExLoad,
    input  logic [4:0]       i_ExRd,
    input  logic             i_BrTaken,
    input  logic             i_Event,
    input  logic             i_Resume,
    output logic             o_HoldIF,
    output logic             o_StallEn,
    output logic             o_FlushEn,
    output logic             o_Halted,
    output logic [1:0]       o_State,
    output logic [CNT_W-1:0] o_StallCnt
);

    localparam int DMAX = (DRAIN_CYC > LOAD_LAT) ? DRAIN_CYC : LOAD_LAT;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC - 1);
    localparam logic [DW-1:0] LDST_INIT  = DW'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic             hazard;
    logic             hold, stall, flush, halted;

    assign hazard = i_ExLoad && (i_ExRd != 5'd0) &&
                    ((i_UseRs1 && (i_Rs1 == i_ExRd)) || (i_UseRs2 && (i_Rs2 == i_ExRd)));

    // A redirect always wins: it kills the ID instruction, so stalling it is pointless.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        halted  = 1'b0;
        case (state_q)
            RUN: begin
                if (i_BrTaken) begin
                    flush = 1'b1;
                end else if (i_Event) begin
                    hold    = 1'b1;
                    stall   = 1'b1;
                    state_d = DRAIN;
                    cnt_d   = DRAIN_INIT;
                end else if (hazard) begin
                    hold  = 1'b1;
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LDSTALL;
                        cnt_d   = LDST_INIT;
                    end
                end
            end
            LDSTALL: begin
                if (i_BrTaken) begin
                    flush   = 1'b1;
                    state_d = RUN;
                end else begin
                    hold  = 1'b1;
                    stall = 1'b1;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - DW'(1);
                end
            end
            DRAIN: begin
                // A redirect here means the event itself was on the wrong path.
                if (i_BrTaken) begin
                    flush   = 1'b1;
                    state_d = RUN;
                end else begin
                    hold  = 1'b1;
                    stall = 1'b1;
                    if (cnt_q == '0) state_d = HALT;
                    else             cnt_d   = cnt_q - DW'(1);
                end
            end
            HALT: begin
                hold   = 1'b1;
                stall  = 1'b1;
                halted = 1'b1;
                if (i_Resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall && (state_q != HALT) && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rstn) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign o_HoldIF   = i_Rstn && hold;
    assign o_StallEn  = i_Rstn && stall;
    assign o_FlushEn  = i_Rstn && flush;
    assign o_Halted   = i_Rstn && halted;
    assign o_State    = i_Rstn ? state_q : 2'd0;
    assign o_StallCnt = i_Rstn ? stallCnt_q : '0;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Scoreboard bench for core_hazard_ctrl: dutA uses defaults (LOAD_LAT=1, CNT_W=32),
// dutB uses LOAD_LAT=3, CNT_W=4 to exercise the multi-cycle stall and saturation.
module tb_core_hazard_ctrl;

    typedef struct packed {
        logic       rstn;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       exLoad;
        logic [4:0] exRd;
        logic       br;
        logic       ev;
        logic       res;
    } in_t;

    typedef struct packed {
        logic        hold;
        logic        stall;
        logic        flush;
        logic        halted;
        logic [1:0]  state;
        logic [31:0] cnt;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    in_t  inA, inB;
    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;

    logic        oHoldA, oStallA, oFlushA, oHaltedA;
    logic [1:0]  oStateA;
    logic [31:0] oCntA;
    logic        oHoldB, oStallB, oFlushB, oHaltedB;
    logic [1:0]  oStateB;
    logic [3:0]  oCntB;
    exp_t        gotA, gotB;

    assign gotA = {oHoldA, oStallA, oFlushA, oHaltedA, oStateA, oCntA};
    assign gotB = {oHoldB, oStallB, oFlushB, oHaltedB, oStateB, 28'd0, oCntB};

    always #5 clk = ~clk;

    core_hazard_ctrl dutA (
        .i_Clk(clk), .i_Rstn(rstn),
        .i_Rs1(inA.rs1), .i_Rs2(inA.rs2), .i_UseRs1(inA.use1), .i_UseRs2(inA.use2),
        .i_ExLoad(inA.exLoad), .i_ExRd(inA.exRd), .i_BrTaken(inA.br),
        .i_Event(inA.ev), .i_Resume(inA.res),
        .o_HoldIF(oHoldA), .o_StallEn(oStallA), .o_FlushEn(oFlushA),
        .o_Halted(oHaltedA), .o_State(oStateA), .o_StallCnt(oCntA)
    );

    core_hazard_ctrl #(.LOAD_LAT(3), .DRAIN_CYC(3), .CNT_W(4)) dutB (
        .i_Clk(clk), .i_Rstn(rstn),
        .i_Rs1(inB.rs1), .i_Rs2(inB.rs2), .i_UseRs1(inB.use1), .i_UseRs2(inB.use2),
        .i_ExLoad(inB.exLoad), .i_ExRd(inB.exRd), .i_BrTaken(inB.br),
        .i_Event(inB.ev), .i_Resume(inB.res),
        .o_HoldIF(oHoldB), .o_StallEn(oStallB), .o_FlushEn(oFlushB),
        .o_Halted(oHaltedB), .o_State(oStateB), .o_StallCnt(oCntB)
    );

    // kind: 0 idle, 1 lw x5 -> add rs1=x5, 2 x0 dest, 3 rs1 unused, 4 rs2 hazard,
    // 5 matching regs but EX not a load, 6 reset asserted with hazard inputs.
    function automatic in_t mkS(int kind, logic [2:0] ctl);
        in_t v;
        v      = '0;
        v.rstn = 1'b1;
        case (kind)
            1: begin v.rs1 = 5'd5; v.use1 = 1'b1; v.exLoad = 1'b1; v.exRd = 5'd5; end
            2: begin v.use1 = 1'b1; v.exLoad = 1'b1; end
            3: begin v.rs1 = 5'd5; v.exLoad = 1'b1; v.exRd = 5'd5; end
            4: begin v.rs1 = 5'd5; v.use1 = 1'b1; v.rs2 = 5'd7; v.use2 = 1'b1;
                     v.exLoad = 1'b1; v.exRd = 5'd7; end
            5: begin v.rs1 = 5'd5; v.use1 = 1'b1; v.exRd = 5'd5; end
            6: begin v.rstn = 1'b0; v.rs1 = 5'd5; v.use1 = 1'b1; v.exLoad = 1'b1;
                     v.exRd = 5'd5; end
            default: ;
        endcase
        {v.br, v.ev, v.res} = ctl;
        return v;
    endfunction

    // flags = {hold, stall, flush, halted}
    function automatic exp_t mkE(logic [3:0] flags, logic [1:0] st, int c);
        return {flags, st, 32'(c)};
    endfunction

    task automatic drive(bit sel, in_t v, exp_t e);
        rstn = v.rstn;
        if (sel) begin inB = v; inA = mkS(0, 3'b000); end
        else     begin inA = v; inB = mkS(0, 3'b000); end
        sbq.push_back(e);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rstn = 1'b0;
        inA  = mkS(0, 3'b000);
        inB  = mkS(0, 3'b000);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        in_t  st [3];
        exp_t ex [3];
        exp_t want;
        st = '{mkS(6, 3'b110), mkS(6, 3'b011), mkS(0, 3'b000)};
        ex = '{mkE(4'b0000, 2'd0, 0), mkE(4'b0000, 2'd0, 0), mkE(4'b0000, 2'd0, 0)};
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(1'b0, st[i], ex[i]);
            #3;
            want = sbq.pop_front();
            checks++;
            if (gotA !== want) begin
                errors++;
                $display("[TB] FAIL reset[%0d]: got %h expected %h", i, gotA, want);
            end
        end
    endtask

    task automatic test_load_use_lat1();
        in_t  st [3];
        exp_t ex [3];
        exp_t want;
        st = '{mkS(1, 3'b000), mkS(0, 3'b000), mkS(0, 3'b000)};
        ex = '{mkE(4'b1100, 2'd0, 0), mkE(4'b0000, 2'd0, 1), mkE(4'b0000, 2'd0, 1)};
        doReset();
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(1'b0, st[i], ex[i]);
            #3;
            want = sbq.pop_front();
            checks++;
            if (gotA !== want) begin
                errors++;
                $display("[TB] FAIL load_use_lat1[%0d]: got %h expected %h", i, gotA, want);
            end
        end
    endtask

    task automatic test_no_hazard();
        in_t  st [5];
        exp_t ex [5];
        exp_t want;
        st = '{mkS(2, 3'b000), mkS(3, 3'b000), mkS(4, 3'b000), mkS(5, 3'b000),
               mkS(0, 3'b000)};
        ex = '{mkE(4'b0000, 2'd0, 0), mkE(4'b0000, 2'd0, 0), mkE(4'b1100, 2'd0, 0),
               mkE(4'b0000, 2'd0, 1), mkE(4'b0000, 2'd0, 1)};
        doReset();
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(1'b0, st[i], ex[i]);
            #3;
            want = sbq.pop_front();
            checks++;
            if (gotA !== want) begin
                errors++;
                $display("[TB] FAIL no_hazard[%0d]: got %h expected %h", i, gotA, want);
            end
        end
    endtask

    task automatic test_ldstall_lat3();
        in_t  st [9];
        exp_t ex [9];
        exp_t want;
        st = '{mkS(1, 3'b000), mkS(0, 3'b000), mkS(0, 3'b000), mkS(0, 3'b000),
               mkS(1, 3'b000), mkS(0, 3'b010), mkS(0, 3'b100), mkS(0, 3'b000),
               mkS(0, 3'b000)};
        ex = '{mkE(4'b1100, 2'd0, 0), mkE(4'b1100, 2'd1, 1), mkE(4'b1100, 2'd1, 2),
               mkE(4'b0000, 2'd0, 3), mkE(4'b1100, 2'd0, 3), mkE(4'b1100, 2'd1, 4),
               mkE(4'b0010, 2'd1, 5), mkE(4'b0000, 2'd0, 5), mkE(4'b0000, 2'd0, 5)};
        doReset();
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(1'b1, st[i], ex[i]);
            #3;
            want = sbq.pop_front();
            checks++;
            if (gotB !== want) begin
                errors++;
                $display("[TB] FAIL ldstall_lat3[%0d]: got %h expected %h", i, gotB, want);
            end
        end
    endtask

    task automatic test_priority();
        in_t  st [6];
        exp_t ex [6];
        exp_t want;
        st = '{mkS(1, 3'b100), mkS(0, 3'b110), mkS(1, 3'b010), mkS(0, 3'b000),
               mkS(0, 3'b100), mkS(0, 3'b000)};
        ex = '{mkE(4'b0010, 2'd0, 0), mkE(4'b0010, 2'd0, 0), mkE(4'b1100, 2'd0, 0),
               mkE(4'b1100, 2'd2, 1), mkE(4'b0010, 2'd2, 2), mkE(4'b0000, 2'd0, 2)};
        doReset();
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(1'b0, st[i], ex[i]);
            #3;
            want = sbq.pop_front();
            checks++;
            if (gotA !== want) begin
                errors++;
                $display("[TB] FAIL priority[%0d]: got %h expected %h", i, gotA, want);
            end
        end
    endtask

    task automatic test_halt_resume();
        in_t  st [9];
        exp_t ex [9];
        exp_t want;
        st = '{mkS(0, 3'b010), mkS(0, 3'b000), mkS(0, 3'b000), mkS(0, 3'b000),
               mkS(0, 3'b000), mkS(1, 3'b110), mkS(0, 3'b001), mkS(0, 3'b000),
               mkS(0, 3'b000)};
        ex = '{mkE(4'b1100, 2'd0, 0), mkE(4'b1100, 2'd2, 1), mkE(4'b1100, 2'd2, 2),
               mkE(4'b1100, 2'd2, 3), mkE(4'b1101, 2'd3, 4), mkE(4'b1101, 2'd3, 4),
               mkE(4'b1101, 2'd3, 4), mkE(4'b0000, 2'd0, 4), mkE(4'b0000, 2'd0, 4)};
        doReset();
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(1'b0, st[i], ex[i]);
            #3;
            want = sbq.pop_front();
            checks++;
            if (gotA !== want) begin
                errors++;
                $display("[TB] FAIL halt_resume[%0d]: got %h expected %h", i, gotA, want);
            end
        end
    endtask

    // Back-to-back hazards keep dutB stalled for 21 cycles; the 4-bit counter pins at 15,
    // then an event parks it in HALT and reset must return it to RUN with a cleared count.
    task automatic test_saturate_reset();
        in_t  st [29];
        exp_t ex [29];
        exp_t want;
        for (int i = 0; i < 21; i++) begin
            st[i] = mkS(1, 3'b000);
            ex[i] = mkE(4'b1100, (i % 3 == 0) ? 2'd0 : 2'd1, (i < 15) ? i : 15);
        end
        st[21] = mkS(0, 3'b000); ex[21] = mkE(4'b0000, 2'd0, 15);
        st[22] = mkS(0, 3'b010); ex[22] = mkE(4'b1100, 2'd0, 15);
        for (int i = 23; i < 26; i++) begin
            st[i] = mkS(0, 3'b000);
            ex[i] = mkE(4'b1100, 2'd2, 15);
        end
        st[26] = mkS(0, 3'b000); ex[26] = mkE(4'b1101, 2'd3, 15);
        st[27] = mkS(6, 3'b010); ex[27] = mkE(4'b0000, 2'd0, 0);
        st[28] = mkS(0, 3'b000); ex[28] = mkE(4'b0000, 2'd0, 0);
        doReset();
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(1'b1, st[i], ex[i]);
            #3;
            want = sbq.pop_front();
            checks++;
            if (gotB !== want) begin
                errors++;
                $display("[TB] FAIL saturate_reset[%0d]: got %h expected %h", i, gotB, want);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        inA  = mkS(0, 3'b000);
        inB  = mkS(0, 3'b000);
        $display("[TB] starting core_hazard_ctrl bench");
        test_reset();
        test_load_use_lat1();
        test_no_hazard();
        test_ldstall_lat3();
        test_priority();
        test_halt_resume();
        test_saturate_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
